// File: rtl/ifetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage.
package ifetch_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BC_W           = $clog2(BYTES_PER_WORD);

   typedef enum logic {
      FETCH,
      WAIT
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetched words with flush and occupancy count.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  entry_t                 push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output entry_t                 head_o,
   output logic                   valid_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;

   // Storage, pointers and count; flush drops any same-cycle push or pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Byte-serial instruction fetch: assembles big-endian words from a byte-wide
// memory and queues them with their PCs. Optional statistics counters are
// built when IFETCH_STATS_EN is defined.
module inst_fetch_unit
   import ifetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd,
   input  logic [7:0]        imem_data,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              inst_valid,
   output logic [31:0]       inst,
   output logic [31:0]       inst_pc,
   input  logic              inst_ready,
   output logic [15:0]       stat_fetched,
   output logic [7:0]        stat_flushes
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   state_e            state_q, state_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [23:0]       asm_q, asm_d;
   logic              rd;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  count;
   entry_t            push_entry;
   entry_t            head;

   // Fetch state, byte counter, PC and assembly register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         byte_cnt_q <= '0;
         fetch_pc_q <= RESET_PC;
         asm_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         fetch_pc_q <= fetch_pc_d;
         asm_q      <= asm_d;
      end
   end

   // Next-state: a word is only started when the FIFO has room, so the push
   // on its last byte never finds the FIFO full
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      fetch_pc_d = fetch_pc_q;
      asm_d      = asm_q;
      rd         = 1'b0;
      push       = 1'b0;
      case (state_q)
         FETCH: begin
            if (byte_cnt_q == '0 && count == CNT_W'(DEPTH)) begin
               state_d = WAIT;
            end else begin
               rd    = 1'b1;
               asm_d = {asm_q[15:0], imem_data};
               if (byte_cnt_q == BC_W'(BYTES_PER_WORD - 1)) begin
                  push       = 1'b1;
                  byte_cnt_d = '0;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end else begin
                  byte_cnt_d = byte_cnt_q + BC_W'(1);
               end
            end
         end
         WAIT: begin
            if (count < CNT_W'(DEPTH)) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      if (redirect) begin
         state_d    = FETCH;
         byte_cnt_d = '0;
         fetch_pc_d = redirect_pc & ~32'h3;
         push       = 1'b0;
      end
   end

   assign imem_rd    = rd & ~rst;
   assign imem_addr  = fetch_pc_q[ADDR_W-1:0] + ADDR_W'(byte_cnt_q);
   assign pop        = inst_valid & inst_ready;
   assign push_entry = '{pc: fetch_pc_q, inst: {asm_q, imem_data}};

   ifetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect),
      .head_o      (head),
      .valid_o     (inst_valid),
      .count_o     (count)
   );

   assign inst    = head.inst;
   assign inst_pc = head.pc;

`ifdef IFETCH_STATS_EN
   logic [15:0] fetched_q;
   logic [7:0]  flushes_q;

   // Saturating counts of pushed words and taken redirects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetched_q <= '0;
         flushes_q <= '0;
      end else begin
         if (push && fetched_q != '1) begin
            fetched_q <= fetched_q + 16'd1;
         end
         if (redirect && flushes_q != '1) begin
            flushes_q <= flushes_q + 8'd1;
         end
      end
   end

   assign stat_fetched = fetched_q;
   assign stat_flushes = flushes_q;
`else
   assign stat_fetched = '0;
   assign stat_flushes = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_inst_fetch_unit;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam int unsigned MEM_SZ   = 1 << ADDR_W;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rd;
   logic [7:0]        imem_data;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              inst_valid;
   logic [31:0]       inst;
   logic [31:0]       inst_pc;
   logic              inst_ready;
   logic [15:0]       stat_fetched;
   logic [7:0]        stat_flushes;

   logic [7:0] mem [MEM_SZ];

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc;
   int          m_nb;
   logic [31:0] m_word;
   bit          m_wait;
   logic [63:0] m_q [$];
   int          m_fetched;
   int          m_flushes;
   logic [31:0] pops [$];

   inst_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_addr    (imem_addr),
      .imem_rd      (imem_rd),
      .imem_data    (imem_data),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .inst_valid   (inst_valid),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_ready   (inst_ready),
      .stat_fetched (stat_fetched),
      .stat_flushes (stat_flushes)
   );

   assign imem_data = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_fetched();
`ifdef IFETCH_STATS_EN
      return (m_fetched > 16'hFFFF) ? 16'hFFFF : 16'(m_fetched);
`else
      return 16'h0;
`endif
   endfunction

   function automatic logic [7:0] exp_flushes();
`ifdef IFETCH_STATS_EN
      return (m_flushes > 8'hFF) ? 8'hFF : 8'(m_flushes);
`else
      return 8'h0;
`endif
   endfunction

   task automatic model_reset();
      m_pc      = RESET_PC;
      m_nb      = 0;
      m_word    = '0;
      m_wait    = 1'b0;
      m_q.delete();
      m_fetched = 0;
      m_flushes = 0;
   endtask

   // Compare DUT outputs to the model, then advance the model by one clock
   task automatic compare_and_advance();
      bit          exp_rd;
      int unsigned exp_addr;
      int          sz;
      if (rst) begin
         chk("rst_valid", 64'(inst_valid), 64'h0);
         chk("rst_rd", 64'(imem_rd), 64'h0);
         chk("rst_inst", 64'(inst), 64'h0);
         chk("rst_pc", 64'(inst_pc), 64'h0);
         chk("rst_fetched", 64'(stat_fetched), 64'h0);
         chk("rst_flushes", 64'(stat_flushes), 64'h0);
         model_reset();
         return;
      end
      sz       = m_q.size();
      exp_rd   = !m_wait && !(m_nb == 0 && sz == DEPTH);
      exp_addr = (m_pc + 32'(m_nb)) % MEM_SZ;
      chk("imem_rd", 64'(imem_rd), 64'(exp_rd));
      chk("imem_addr", 64'(imem_addr), 64'(exp_addr));
      chk("inst_valid", 64'(inst_valid), 64'(sz != 0));
      if (sz != 0) begin
         chk("inst", 64'(inst), 64'(m_q[0][31:0]));
         chk("inst_pc", 64'(inst_pc), 64'(m_q[0][63:32]));
      end
      chk("stat_fetched", 64'(stat_fetched), 64'(exp_fetched()));
      chk("stat_flushes", 64'(stat_flushes), 64'(exp_flushes()));

      if (redirect) begin
         m_q.delete();
         m_nb   = 0;
         m_wait = 1'b0;
         m_pc   = {redirect_pc[31:2], 2'b00};
         m_flushes++;
      end else begin
         if (sz != 0 && inst_ready) void'(m_q.pop_front());
         if (!exp_rd) begin
            if (m_wait) begin
               if (sz < DEPTH) m_wait = 1'b0;
            end else begin
               m_wait = 1'b1;
            end
         end else begin
            m_word = (m_word << 8) | 32'(mem[exp_addr]);
            m_nb++;
            if (m_nb == 4) begin
               m_q.push_back({m_pc, m_word});
               m_pc = m_pc + 32'd4;
               m_nb = 0;
               m_fetched++;
            end
         end
      end
   endtask

   // One clock: check/advance mid-cycle, return just after the next rising edge
   task automatic step();
      @(negedge clk);
      compare_and_advance();
      if (!rst && inst_valid && inst_ready) pops.push_back(inst_pc);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b1;
      for (int i = 0; i < int'(MEM_SZ); i++) mem[i] = 8'($urandom);
      mem[0]  = 8'h8C; mem[1]  = 8'h01; mem[2]  = 8'h00; mem[3]  = 8'h04;
      mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
      mem[28] = 8'h01; mem[29] = 8'h23; mem[30] = 8'h45; mem[31] = 8'h67;
      #1;
      chk("init_valid", 64'(inst_valid), 64'h0);

      // first word latency after reset release
      do_reset();
      chk("c0_rd", 64'(imem_rd), 64'h1);
      chk("c0_addr", 64'(imem_addr), 64'h0);
      for (int i = 0; i < 3; i++) step();
      chk("c3_valid", 64'(inst_valid), 64'h0);
      step();
      chk("c4_valid", 64'(inst_valid), 64'h1);
      chk("c4_inst", 64'(inst), 64'h8C010004);
      chk("c4_pc", 64'(inst_pc), 64'h0);

      // stall with consumer not ready, then drain in order
      inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) step();
      chk("stall_rd", 64'(imem_rd), 64'h0);
      chk("stall_head", 64'(inst_pc), 64'h0);
      for (int i = 0; i < 12; i++) step();
      chk("wait_rd", 64'(imem_rd), 64'h0);
      chk("wait_addr", 64'(imem_addr), 64'h8);
      pops.delete();
      inst_ready = 1'b1;
      for (int i = 0; i < 40 && pops.size() < 3; i++) step();
      chk("drain_count", 64'(pops.size()), 64'd3);
      if (pops.size() >= 3) begin
         chk("drain0", 64'(pops[0]), 64'h0);
         chk("drain1", 64'(pops[1]), 64'h4);
         chk("drain2", 64'(pops[2]), 64'h8);
      end

      // redirect mid-word to an unaligned target
      do_reset();
      step();
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h12;
      step();
      redirect = 1'b0;
      chk("redir_valid", 64'(inst_valid), 64'h0);
      chk("redir_addr", 64'(imem_addr), 64'h10);
      for (int i = 0; i < 3; i++) step();
      chk("redir_n4_valid", 64'(inst_valid), 64'h0);
      step();
      chk("redir_n5_valid", 64'(inst_valid), 64'h1);
      chk("redir_n5_inst", 64'(inst), 64'hDEADBEEF);
      chk("redir_n5_pc", 64'(inst_pc), 64'h10);

      // address wrap at the top of the byte memory
      redirect    = 1'b1;
      redirect_pc = 32'h1C;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("wrap_inst", 64'(inst), 64'h01234567);
      chk("wrap_pc", 64'(inst_pc), 64'h1C);
      chk("wrap_addr", 64'(imem_addr), 64'h0);
      chk("wrap_rd", 64'(imem_rd), 64'h1);
      for (int i = 0; i < 4; i++) step();
      chk("wrap_next_pc", 64'(inst_pc), 64'h20);
      chk("wrap_next_inst", 64'(inst), 64'h8C010004);

      // asynchronous reset mid-word with one entry buffered
      inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) step();
      chk("async_pre_valid", 64'(inst_valid), 64'h1);
      #1 rst = 1'b1;
      #1;
      chk("async_valid", 64'(inst_valid), 64'h0);
      chk("async_rd", 64'(imem_rd), 64'h0);
      step();
      rst = 1'b0;
      #1;
      chk("async_restart_addr", 64'(imem_addr), 64'(RESET_PC[ADDR_W-1:0]));
      chk("async_restart_rd", 64'(imem_rd), 64'h1);
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("async_restart_pc", 64'(inst_pc), 64'(RESET_PC));

      // statistics: three pushes then one redirect
      do_reset();
      for (int i = 0; i < 12; i++) step();
      redirect    = 1'b1;
      redirect_pc = 32'h4;
      step();
      redirect = 1'b0;
`ifdef IFETCH_STATS_EN
      chk("stat_fetched3", 64'(stat_fetched), 64'd3);
      chk("stat_flushes1", 64'(stat_flushes), 64'd1);
`else
      chk("stat_fetched0", 64'(stat_fetched), 64'd0);
      chk("stat_flushes0", 64'(stat_flushes), 64'd0);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         inst_ready  = ($urandom_range(0, 9) < 7);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom;
         rst         = ($urandom_range(0, 299) == 0);
         if (rst) redirect = 1'b0;
         step();
      end
      rst      = 1'b0;
      redirect = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
